multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control unit directly upstream of the datapath operand/result muxes. Fetches an instruction word through a valid/ready handshake and holds it in an instruction register (IR). It exposes the IR fields RDst3 and Src2 and generates the mux selects WE, ALUSrc2 and ALUorM, plus ALU opcode, register write enable and data-memory request. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states.

Parameters:
N, 8, datapath width; width of the Src2 field.
P, 8, program counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
instr  in  N+8  instruction word: [N+7:N+4] opcode, [N+3:N+2] RDst, [N+1:N] RSrc1, [N-1:0] Src2.
instr_valid  in  1  instruction word valid.
instr_ready  out  1  control unit accepts instruction.
pc  out  P  address of the next instruction to fetch.
mem_ack  in  1  data memory has completed the current request.
mem_req  out  1  data memory request (read, or write when WE=1).
RDst3  out  2  IR destination register field.
RSrc1  out  2  IR source-1 register field.
Src2  out  N  IR operand-2 field (register index in [N-1:N-2], or immediate).
ALUOp  out  3  ALU operation (opcode[2:0]).
WE  out  1  store in progress; Mux1 select and memory write qualifier.
ALUSrc2  out  1  Mux2 select: 0 = RD2, 1 = Src2 immediate.
ALUorM  out  1  Mux3 select: 0 = ALU result R, 1 = ReadData.
RegWrite  out  1  register file write strobe.

Behaviour:
- Reset: one clock, synchronous, active-high. Takes priority over everything, including mid-instruction (e.g. in MEM).
  - Next state is FETCH; pc=0; IR=0 (decodes as NOP).
  - mem_req, WE and RegWrite are 0 during the reset cycle and on the following edge.
  - instr_ready is 0 while rst=1.
  - A reset in MEM abandons the access; mem_req is low on the cycle after rst is sampled.
- Opcode map, bits [2:0]: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LD, 111 ST. Bit 3 is the immediate flag.
- Combinational decodes from IR:
  - ALUOp = opcode[2:0].
  - ALUSrc2 = opcode[3] | LD | ST (address = RD1 + Src2 offset).
  - ALUorM = LD.
  - These are stable from DECODE until the next IR load.
- FETCH:
  - instr_ready=1.
  - On instr_valid & instr_ready: IR<=instr, pc<=pc+1 (modulo 2^P), go to DECODE.
  - Otherwise stay in FETCH; pc holds.
- DECODE (1 cycle): NOP goes to FETCH; all other opcodes go to EXEC.
- EXEC (1 cycle): ALU ops go to WB; LD/ST go to MEM.
- MEM:
  - mem_req=1 until mem_ack is sampled high, including an ack in the first MEM cycle.
  - On ack: LD goes to WB; ST goes to FETCH.
  - No timeout.
- WB: RegWrite=1 for exactly one cycle, then go to FETCH.
- WE = 1 in DECODE, EXEC and MEM of a ST only, so Mux1 selects RDst3 as the store-data register. WE is 0 in all other states and opcodes.
- Ignored inputs:
  - mem_ack outside MEM.
  - instr_valid outside FETCH; instr_ready=0 there.
- Latency from the handshake edge:
  - ALU op: RegWrite high 3 cycles later (DECODE, EXEC, WB); next FETCH on cycle 4.
  - LD: 4 cycles plus ack wait.
  - ST: 3 cycles plus ack wait.
  - NOP: back in FETCH 2 cycles later.
- The IR is only written in FETCH. Field outputs are held stable throughout the instruction.

Test Plan:
1. Reset mid-MEM of an LD with mem_ack=0, rst high 2 cycles -> mem_req=0 from the first sampled reset edge; pc=0; RegWrite=0, WE=0; instr_ready=1 on the first cycle after rst falls.
2. ADD: instr={4'b0001,2'd2,2'd1,8'hC0}, valid held -> ALUOp=001, ALUSrc2=0, ALUorM=0, RDst3=2, Src2=8'hC0; RegWrite high exactly 1 cycle, 3 cycles after the handshake; pc 0->1.
3. ADDI: instr={4'b1001,2'd3,2'd0,8'h05} -> ALUSrc2=1, ALUOp=001, WE=0; single RegWrite pulse.
4. LD with offset 8'h10, mem_ack raised 3 cycles after mem_req -> mem_req high 4 cycles, WE=0; then WB with ALUorM=1 and RegWrite for 1 cycle; instr_ready returns next cycle.
5. ST with mem_ack high in the first MEM cycle -> WE=1 across DECODE/EXEC/MEM; mem_req for 1 cycle; no RegWrite; FETCH follows. A spurious mem_ack in FETCH has no effect.
6. 256 NOPs with instr_valid toggling 1/0 -> FSM stalls in FETCH while valid=0 and pc holds; pc reaches 8'hFF and wraps to 0 on the 256th fetch.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: fetches an instruction word into the IR and sequences
// it through FETCH/DECODE/EXEC/MEM/WB, driving the datapath mux selects and strobes.
module multicycle_ctrl #(
  parameter int N = 8,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N+7:0] instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [P-1:0] pc,
  input  logic         mem_ack,
  output logic         mem_req,
  output logic [1:0]   RDst3,
  output logic [1:0]   RSrc1,
  output logic [N-1:0] Src2,
  output logic [2:0]   ALUOp,
  output logic         WE,
  output logic         ALUSrc2,
  output logic         ALUorM,
  output logic         RegWrite,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_ST  = 3'b111;

  state_t       state;
  logic [N+7:0] ir;
  logic [3:0]   opcode;
  logic         is_ld;
  logic         is_st;

  assign opcode = ir[N+7:N+4];
  assign is_ld  = (opcode[2:0] == OP_LD);
  assign is_st  = (opcode[2:0] == OP_ST);

  // Handshake: instr is taken on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in FETCH outside reset. mem_req stays high in MEM
  // until mem_ack is sampled high on a rising edge; mem_ack is ignored elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            pc    <= pc + P'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= (opcode[2:0] == OP_NOP) ? S_FETCH : S_EXEC;
        S_EXEC:   state <= (is_ld || is_st) ? S_MEM : S_WB;
        S_MEM: begin
          if (mem_ack) state <= is_ld ? S_WB : S_FETCH;
        end
        S_WB:     state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // IR field and operand-select decodes; stable from DECODE until the next IR load.
  assign RDst3   = ir[N+3:N+2];
  assign RSrc1   = ir[N+1:N];
  assign Src2    = ir[N-1:0];
  assign ALUOp   = opcode[2:0];
  assign ALUSrc2 = opcode[3] | is_ld | is_st;
  assign ALUorM  = is_ld;

  // Strobes are forced low while rst is asserted so a reset in MEM drops the request at once.
  assign instr_ready = (state == S_FETCH) && !rst;
  assign mem_req     = (state == S_MEM) && !rst;
  assign RegWrite    = (state == S_WB) && !rst;
  assign WE          = is_st && !rst &&
                       ((state == S_DECODE) || (state == S_EXEC) || (state == S_MEM));

  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle schedules built from
// the opcode and the chosen memory wait, compared against the DUT on every cycle.
module tb_multicycle_ctrl;

  localparam int N  = 8;
  localparam int P  = 8;
  localparam int IW = N + 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [P-1:0]  pc;
  logic          mem_ack;
  logic          mem_req;
  logic [1:0]    RDst3;
  logic [1:0]    RSrc1;
  logic [N-1:0]  Src2;
  logic [2:0]    ALUOp;
  logic          WE;
  logic          ALUSrc2;
  logic          ALUorM;
  logic          RegWrite;
  logic [2:0]    dbg_state;

  multicycle_ctrl #(.N(N), .P(P)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .mem_ack(mem_ack), .mem_req(mem_req),
    .RDst3(RDst3), .RSrc1(RSrc1), .Src2(Src2), .ALUOp(ALUOp), .WE(WE),
    .ALUSrc2(ALUSrc2), .ALUorM(ALUorM), .RegWrite(RegWrite), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  // Each cycle record: [0]=mem_req [1]=WE [2]=RegWrite [3]=mem_ack to drive.
  logic [3:0]    exp_q[$];
  logic [3:0]    cur;
  logic          cur_fetch;
  logic [P-1:0]  pc_m;
  logic [IW-1:0] ir_m;
  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;
  int            hs_cyc = 0;
  int            memc, wec, rwc, rw_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur       = '0;
    cur_fetch = 1'b1;
    pc_m      = '0;
    ir_m      = '0;
  endtask

  // Cycle schedule of an accepted instruction: DECODE, then EXEC, MEM x(d+1), WB as needed.
  task automatic build_sched(input logic [IW-1:0] ins, input int d);
    logic [2:0] op;
    logic       st;
    op = ins[N+6:N+4];
    st = (op == 3'b111);
    exp_q.delete();
    exp_q.push_back({2'b00, st, 1'b0});
    if (op != 3'b000) begin
      exp_q.push_back({2'b00, st, 1'b0});
      if (op == 3'b110 || op == 3'b111) begin
        for (int i = 0; i <= d; i++) exp_q.push_back({(i == d), 1'b0, st, 1'b1});
        if (op == 3'b110) exp_q.push_back(4'b0100);
      end else begin
        exp_q.push_back(4'b0100);
      end
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic v, input logic [IW-1:0] ins, input int d);
    logic [3:0] op;
    @(negedge clk);
    ncyc++;
    op = ir_m[N+7:N+4];
    chk("instr_ready", instr_ready, cur_fetch);
    chk("pc", pc, pc_m);
    chk("mem_req", mem_req, cur[0]);
    chk("WE", WE, cur[1]);
    chk("RegWrite", RegWrite, cur[2]);
    chk("RDst3", RDst3, ir_m[N+3:N+2]);
    chk("RSrc1", RSrc1, ir_m[N+1:N]);
    chk("Src2", Src2, ir_m[N-1:0]);
    chk("ALUOp", ALUOp, op[2:0]);
    chk("ALUSrc2", ALUSrc2, op[3] | (op[2:1] == 2'b11));
    chk("ALUorM", ALUorM, (op[2:0] == 3'b110));
    if (mem_req === 1'b1) memc++;
    if (WE === 1'b1) wec++;
    if (RegWrite === 1'b1) begin
      rwc++;
      if (rw_lat < 0) rw_lat = ncyc - hs_cyc;
    end
    if (cur_fetch) begin
      instr_valid = v;
      instr       = ins;
      mem_ack     = 1'($urandom_range(0, 1));
    end else begin
      instr_valid = 1'($urandom_range(0, 1));
      instr       = IW'($urandom);
      mem_ack     = cur[0] ? cur[3] : 1'($urandom_range(0, 1));
    end
    if (cur_fetch) begin
      if (v) begin
        ir_m = ins;
        pc_m = pc_m + P'(1);
        build_sched(ins, d);
        cur       = exp_q.pop_front();
        cur_fetch = 1'b0;
        hs_cyc    = ncyc;
        memc = 0; wec = 0; rwc = 0; rw_lat = -1;
      end
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur       = '0;
      cur_fetch = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [IW-1:0] ins, input int d);
    cycle(1'b1, ins, d);
    for (int k = 0; k < 20 && !cur_fetch; k++) cycle(1'b0, IW'($urandom), 0);
    chk("back_in_fetch", cur_fetch, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_WE", WE, 1'b0);
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_ready", instr_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_pc", pc, '0);
      chk("rst_mem_req_edge", mem_req, 1'b0);
      chk("rst_WE_edge", WE, 1'b0);
      chk("rst_RegWrite_edge", RegWrite, 1'b0);
      chk("rst_ready_edge", instr_ready, 1'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0;
    memc = 0; wec = 0; rwc = 0; rw_lat = -1;
    model_reset();
    do_reset();

    // LD abandoned mid-MEM by a two-cycle reset
    cycle(1'b1, {4'b0110, 2'd1, 2'd2, 8'h10}, 3);
    repeat (3) cycle(1'b0, IW'($urandom), 0);
    chk("midmem_req_before_rst", mem_req, 1'b1);
    do_reset();
    cycle(1'b0, '0, 0);
    chk("ready_after_rst", instr_ready, 1'b1);

    // ADD with register operand
    run_instr({4'b0001, 2'd2, 2'd1, 8'hC0}, 0);
    chk("add_aluop", ALUOp, 3'b001);
    chk("add_alusrc2", ALUSrc2, 1'b0);
    chk("add_aluorm", ALUorM, 1'b0);
    chk("add_rdst3", RDst3, 2'd2);
    chk("add_src2", Src2, 8'hC0);
    chk("add_pc", pc, 8'h01);
    chk("add_rw_pulses", rwc, 1);
    chk("add_rw_latency", rw_lat, 3);

    // ADDI
    run_instr({4'b1001, 2'd3, 2'd0, 8'h05}, 0);
    chk("addi_alusrc2", ALUSrc2, 1'b1);
    chk("addi_aluop", ALUOp, 3'b001);
    chk("addi_we_cycles", wec, 0);
    chk("addi_rw_pulses", rwc, 1);

    // LD, ack in the fourth MEM cycle
    run_instr({4'b0110, 2'd1, 2'd2, 8'h10}, 3);
    chk("ld_memreq_cycles", memc, 4);
    chk("ld_we_cycles", wec, 0);
    chk("ld_aluorm", ALUorM, 1'b1);
    chk("ld_rw_pulses", rwc, 1);
    chk("ld_rw_latency", rw_lat, 7);

    // ST, ack in the first MEM cycle
    run_instr({4'b0111, 2'd0, 2'd3, 8'h20}, 0);
    chk("st_we_cycles", wec, 3);
    chk("st_memreq_cycles", memc, 1);
    chk("st_rw_pulses", rwc, 0);

    // 256 NOPs with valid toggling; pc wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, IW'($urandom), 0);
      run_instr({4'b0000, IW'($urandom) & 12'hFFF}, 0);
      if (i == 254) chk("nop_pc_ff", pc, 8'hFF);
    end
    chk("nop_pc_wrap", pc, 8'h00);

    // randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, IW'($urandom), 0);
      run_instr(IW'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
